// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types and step helpers for the synctimer blocks.
package jellyvl_synctimer_pkg;

   localparam int TIME_WIDTH = 64;

   typedef logic [TIME_WIDTH-1:0] t_time;

   typedef enum logic {
      ADJ_PLUS  = 1'b0,
      ADJ_MINUS = 1'b1
   } t_adj_sign;

   function automatic int unsigned step_int(
      input int unsigned num,
      input int unsigned den
   );
      return (den == 0) ? 0 : num / den;
   endfunction

   function automatic int unsigned step_frac(
      input int unsigned num,
      input int unsigned den
   );
      return (den == 0) ? 0 : num % den;
   endfunction

endpackage

// File: rtl/jellyvl_synctimer_step_gen.sv
// Fractional-rate step generator: NUMERATOR/DENOMINATOR units per clock.
module jellyvl_synctimer_step_gen
   import jellyvl_synctimer_pkg::*;
#(
   parameter int unsigned NUMERATOR   = 10,
   parameter int unsigned DENOMINATOR = 3,
   parameter int          INC_WIDTH   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   output logic [INC_WIDTH-1:0] inc
);

   localparam int unsigned STEP_INT  = step_int(NUMERATOR, DENOMINATOR);
   localparam int unsigned STEP_FRAC = step_frac(NUMERATOR, DENOMINATOR);
   localparam int          ACC_W     = $clog2(DENOMINATOR) + 1;
   localparam int          SUM_W     = ACC_W + 1;

   logic [ACC_W-1:0] acc;
   logic [SUM_W-1:0] sum;
   logic [SUM_W-1:0] sum_wrapped;
   logic             carry;

   always_comb begin
      sum         = SUM_W'(acc) + SUM_W'(STEP_FRAC);
      carry       = (sum >= SUM_W'(DENOMINATOR));
      sum_wrapped = carry ? (sum - SUM_W'(DENOMINATOR)) : sum;
      inc         = INC_WIDTH'(STEP_INT) + INC_WIDTH'(carry);
   end

   // clear restarts the fractional phase at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else begin
         acc <= sum_wrapped[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/jellyvl_synctimer_timer.sv
// Local synctimer time base: fractional stepping, +/-1 slew and override.
module jellyvl_synctimer_timer
   import jellyvl_synctimer_pkg::*;
#(
   parameter int                   TIMER_WIDTH = 64,
   parameter int unsigned          NUMERATOR   = 10,
   parameter int unsigned          DENOMINATOR = 3,
   parameter logic [TIMER_WIDTH-1:0] INIT_TIME = '0,
   parameter int                   TICK_BIT    = 20,
   parameter bit                   SIMULATION  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TIMER_WIDTH-1:0] set_time,
   input  logic                   set_valid,
   input  logic                   adjust_sign,
   input  logic                   adjust_valid,
   output logic                   adjust_ready,
   output logic [TIMER_WIDTH-1:0] current_time,
   output logic                   time_tick
);

   localparam int unsigned STEP_INT = step_int(NUMERATOR, DENOMINATOR);

   if (SIMULATION) begin : g_check
      if (DENOMINATOR == 0) begin : g_den
         $error("DENOMINATOR must be at least 1");
      end
      if (STEP_INT < 2) begin : g_step
         $error("integer step must be at least 2");
      end
      if (TICK_BIT >= TIMER_WIDTH) begin : g_tick
         $error("TICK_BIT must be below TIMER_WIDTH");
      end
   end

   logic [TIMER_WIDTH-1:0] inc;
   logic [TIMER_WIDTH-1:0] adj_delta;
   logic [TIMER_WIDTH-1:0] next_time;
   logic                   xfer;
   logic                   crossing;
   t_adj_sign              sign;

   jellyvl_synctimer_step_gen #(
      .NUMERATOR   (NUMERATOR),
      .DENOMINATOR (DENOMINATOR),
      .INC_WIDTH   (TIMER_WIDTH)
   ) u_step_gen (
      .clk   (clk),
      .reset (reset),
      .clear (set_valid),
      .inc   (inc)
   );

   assign sign         = t_adj_sign'(adjust_sign);
   assign adjust_ready = reset & ~set_valid;
   assign xfer         = adjust_valid & adjust_ready;

   // a minus slew is added as all-ones; the sum wraps modulo 2^W
   always_comb begin
      adj_delta = '0;
      if (xfer) begin
         adj_delta = (sign == ADJ_MINUS) ? '1 : TIMER_WIDTH'(1);
      end
      next_time = current_time + inc + adj_delta;
      crossing  = (next_time[TIMER_WIDTH-1:TICK_BIT]
                   != current_time[TIMER_WIDTH-1:TICK_BIT]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         current_time <= INIT_TIME;
         time_tick    <= 1'b0;
      end else if (set_valid) begin
         current_time <= set_time;
         time_tick    <= 1'b0;
      end else begin
         current_time <= next_time;
         time_tick    <= crossing;
      end
   end

endmodule

// File: tb/tb_jellyvl_synctimer_timer.sv
// Directed vector bench for jellyvl_synctimer_timer.
module tb_jellyvl_synctimer_timer;

   typedef struct {
      bit          dut;
      logic        set_valid;
      logic [63:0] set_time;
      logic        adj_valid;
      logic        adj_sign;
      logic        exp_ready;
      logic [63:0] exp_time;
      logic        exp_tick;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [63:0] a_set_time;
   logic        a_set_valid;
   logic        a_adj_sign;
   logic        a_adj_valid;
   logic        a_ready;
   logic [63:0] a_time;
   logic        a_tick;

   logic [7:0]  b_set_time;
   logic        b_set_valid;
   logic        b_adj_sign;
   logic        b_adj_valid;
   logic        b_ready;
   logic [7:0]  b_time;
   logic        b_tick;

   int errors = 0;
   int checks = 0;

   vec_t vecs[$];

   always #5 clk = ~clk;

   jellyvl_synctimer_timer u_a (
      .clk          (clk),
      .reset        (rst_n),
      .set_time     (a_set_time),
      .set_valid    (a_set_valid),
      .adjust_sign  (a_adj_sign),
      .adjust_valid (a_adj_valid),
      .adjust_ready (a_ready),
      .current_time (a_time),
      .time_tick    (a_tick)
   );

   jellyvl_synctimer_timer #(
      .TIMER_WIDTH (8),
      .TICK_BIT    (4)
   ) u_b (
      .clk          (clk),
      .reset        (rst_n),
      .set_time     (b_set_time),
      .set_valid    (b_set_valid),
      .adjust_sign  (b_adj_sign),
      .adjust_valid (b_adj_valid),
      .adjust_ready (b_ready),
      .current_time (b_time),
      .time_tick    (b_tick)
   );

   task automatic chk(input string name, input int idx,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input bit d, input logic sv, input logic [63:0] st,
                      input logic av, input logic as, input logic er,
                      input logic [63:0] et, input logic ek);
      vec_t v;
      v.dut = d; v.set_valid = sv; v.set_time = st;
      v.adj_valid = av; v.adj_sign = as; v.exp_ready = er;
      v.exp_time = et; v.exp_tick = ek;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      a_set_valid = 0; a_set_time = '0; a_adj_valid = 0; a_adj_sign = 0;
      b_set_valid = 0; b_set_time = '0; b_adj_valid = 0; b_adj_sign = 0;
   endtask

   initial begin
      // plain stepping from reset
      add(0, 0, 0, 0, 0, 1, 64'd3, 0);
      add(0, 0, 0, 0, 0, 1, 64'd6, 0);
      add(0, 0, 0, 0, 0, 1, 64'd10, 0);
      add(0, 0, 0, 0, 0, 1, 64'd13, 0);
      add(0, 0, 0, 0, 0, 1, 64'd16, 0);
      add(0, 0, 0, 0, 0, 1, 64'd20, 0);
      // +1 and -1 slew from 100 with acc cleared
      add(0, 1, 64'd100, 0, 0, 0, 64'd100, 0);
      add(0, 0, 0, 1, 0, 1, 64'd104, 0);
      add(0, 1, 64'd100, 0, 0, 0, 64'd100, 0);
      add(0, 0, 0, 1, 1, 1, 64'd102, 0);
      // override restarts fractional phase
      add(0, 1, 64'h1000, 0, 0, 0, 64'h1000, 0);
      add(0, 0, 0, 0, 0, 1, 64'h1003, 0);
      add(0, 0, 0, 0, 0, 1, 64'h1006, 0);
      add(0, 0, 0, 0, 0, 1, 64'h100A, 0);
      // set beats adjust; request lands the next cycle
      add(0, 1, 64'd500, 1, 1, 0, 64'd500, 0);
      add(0, 0, 0, 1, 1, 1, 64'd502, 0);
      add(0, 0, 0, 0, 0, 1, 64'd505, 0);
      // bit-20 crossing and 64-bit wrap
      add(0, 1, 64'hF_FFFE, 0, 0, 0, 64'hF_FFFE, 0);
      add(0, 0, 0, 0, 0, 1, 64'h10_0001, 1);
      add(0, 0, 0, 0, 0, 1, 64'h10_0004, 0);
      add(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      add(0, 0, 0, 0, 0, 1, 64'd1, 1);
      // narrow timer, tick on bit 4
      add(1, 1, 64'd14, 0, 0, 0, 64'd14, 0);
      add(1, 0, 0, 0, 0, 1, 64'd17, 1);
      add(1, 0, 0, 0, 0, 1, 64'd20, 0);
      add(1, 0, 0, 0, 0, 1, 64'd24, 0);
      add(1, 0, 0, 0, 0, 1, 64'd27, 0);
      add(1, 0, 0, 0, 0, 1, 64'd30, 0);
      add(1, 0, 0, 0, 0, 1, 64'd34, 1);
      // 8-bit wrap counts as a crossing
      add(1, 1, 64'd254, 0, 0, 0, 64'd254, 0);
      add(1, 0, 0, 0, 0, 1, 64'd1, 1);
      add(1, 0, 0, 0, 0, 1, 64'd4, 0);
      add(1, 0, 0, 0, 0, 1, 64'd8, 0);

      rst_n = 1'b0;
      idle_inputs();
      a_adj_valid = 1'b1;
      #1;
      chk("reset_time_a", -1, a_time, 64'd0);
      chk("reset_tick_a", -1, {63'd0, a_tick}, 64'd0);
      chk("reset_ready_a", -1, {63'd0, a_ready}, 64'd0);
      chk("reset_time_b", -1, {56'd0, b_time}, 64'd0);
      a_adj_valid = 1'b0;
      #11;
      rst_n = 1'b1;
      #1;
      chk("release_time_a", -1, a_time, 64'd0);
      chk("release_ready_a", -1, {63'd0, a_ready}, 64'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         idle_inputs();
         if (vecs[i].dut == 0) begin
            a_set_valid = vecs[i].set_valid;
            a_set_time  = vecs[i].set_time;
            a_adj_valid = vecs[i].adj_valid;
            a_adj_sign  = vecs[i].adj_sign;
         end else begin
            b_set_valid = vecs[i].set_valid;
            b_set_time  = vecs[i].set_time[7:0];
            b_adj_valid = vecs[i].adj_valid;
            b_adj_sign  = vecs[i].adj_sign;
         end
         #1;
         if (vecs[i].dut == 0)
            chk("ready_a", i, {63'd0, a_ready}, {63'd0, vecs[i].exp_ready});
         else
            chk("ready_b", i, {63'd0, b_ready}, {63'd0, vecs[i].exp_ready});
         @(posedge clk);
         #1;
         if (vecs[i].dut == 0) begin
            chk("time_a", i, a_time, vecs[i].exp_time);
            chk("tick_a", i, {63'd0, a_tick}, {63'd0, vecs[i].exp_tick});
         end else begin
            chk("time_b", i, {56'd0, b_time}, vecs[i].exp_time);
            chk("tick_b", i, {63'd0, b_tick}, {63'd0, vecs[i].exp_tick});
         end
      end
      idle_inputs();

      // reset asserted mid-sequence takes effect without a clock edge
      rst_n = 1'b0;
      #1;
      chk("midreset_time_a", -1, a_time, 64'd0);
      chk("midreset_time_b", -1, {56'd0, b_time}, 64'd0);
      chk("midreset_ready_b", -1, {63'd0, b_ready}, 64'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_reset_a", -1, a_time, 64'd3);
      chk("after_reset_b", -1, {56'd0, b_time}, 64'd3);
      chk("after_reset_tick_a", -1, {63'd0, a_tick}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jellyvl_synctimer_timer.md
Name: jellyvl_synctimer_timer

Overview:
Local time base for the synctimer.
- Advances a TIMER_WIDTH-bit nanosecond-style counter by a fractional step (NUMERATOR/DENOMINATOR) every clock.
- Accepts single-unit ±1 slew requests from the adjust stage over a valid/ready handshake.
- Accepts a hard time override.
- Produces local_time for the adjust stage and a boundary tick for downstream consumers.

Parameters:
- TIMER_WIDTH, 64: width of the time counter.
- NUMERATOR, 10: clock period numerator (time units per DENOMINATOR clocks).
- DENOMINATOR, 3: clock period denominator; must be ≥1.
- INIT_TIME, 0: value of current_time after reset.
- TICK_BIT, 20: a tick fires whenever bits [TIMER_WIDTH-1:TICK_BIT] of the time change.
- SIMULATION, 1'b1: enables elaboration-time parameter checks.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- set_time  in  TIMER_WIDTH  override value.
- set_valid  in  1  override strobe; one cycle.
- adjust_sign  in  1  0 = +1 extra unit, 1 = −1 unit.
- adjust_valid  in  1  slew request valid.
- adjust_ready  out  1  slew request accepted this cycle.
- current_time  out  TIMER_WIDTH  local time; feeds the adjust stage local_time.
- time_tick  out  1  one-cycle pulse on a TICK_BIT boundary crossing.

Behaviour:
- Constants: STEP_INT = NUMERATOR/DENOMINATOR; STEP_FRAC = NUMERATOR%DENOMINATOR. Fractional accumulator acc has width clog2(DENOMINATOR)+1 and range 0..DENOMINATOR-1.
- Reset (reset low, asynchronous): current_time = INIT_TIME, acc = 0, time_tick = 0. adjust_ready is forced 0 while reset is low.
- Per cycle, when no set is pending:
  - sum = acc + STEP_FRAC.
  - carry = (sum ≥ DENOMINATOR); acc <= sum − (carry ? DENOMINATOR : 0).
  - inc = STEP_INT + carry + adj, where adj = +1 or −1 if a handshake occurred this cycle (per adjust_sign), else 0.
  - current_time <= current_time + inc, modulo 2^TIMER_WIDTH. Wrap-around is silent.
- Handshake: adjust_ready = !set_valid (combinational). A transfer occurs when adjust_valid && adjust_ready. At most one unit is applied per cycle. A request held across N ready cycles is N transfers; the producer deasserts valid after each accepted request.
- Adjust latency: a transfer in cycle N changes the current_time value visible at N+1.
- Override: set_valid in cycle N gives current_time = set_time and acc = 0 at N+1. Normal stepping resumes from N+1, so N+2 = set_time + STEP_INT + carry. The fractional phase restarts.
- Simultaneous set_valid and adjust_valid: set wins. adjust_ready is 0, so the request is not consumed and stays pending.
- time_tick: registered.
  - Asserted at N+1 iff the next value's bits [TIMER_WIDTH-1:TICK_BIT] differ from the current value's.
  - Suppressed (0) for the update caused by an override.
  - Wrap from all-ones to 0 counts as a crossing.
- Monotonicity: require STEP_INT ≥ 2 so a −1 adjust never stalls or reverses time. When SIMULATION = 1, fail elaboration if STEP_INT < 2 or DENOMINATOR = 0.
- Reset mid-operation: all state returns to reset values immediately. The first increment occurs on the first clk edge after release.

Decomposition:
- Package jellyvl_synctimer_pkg:
  - types t_time (logic [TIMER_WIDTH-1:0]) and t_adj_sign;
  - function computing STEP_INT/STEP_FRAC;
  - shared with the adjust stage and the timestamp capture blocks.
- Sub-module jellyvl_synctimer_step_gen:
  - holds the fractional accumulator and emits a registered-free increment (STEP_INT + carry);
  - has a clear input for override;
  - reused by other fractional-rate counters.
- The top level adds the adjust handshake, override mux, time register and tick logic.

Test Plan:
1. Reset release, NUMERATOR=10, DENOMINATOR=3, INIT_TIME=0, no adjust/set → current_time sequence 0, 3, 6, 10, 13, 16, 20; time_tick stays 0.
2. From current_time=100 with acc=0, one adjust_valid cycle with sign=0 → next value 104; with sign=1 → next value 102. adjust_ready=1 in both cases.
3. set_valid with set_time=0x1000 at cycle N → current_time=0x1000 at N+1, then 0x1003, 0x1006, 0x100A. time_tick=0 at N+1.
4. set_valid and adjust_valid (sign=1) in the same cycle N with set_time=500 → adjust_ready=0 at N; 500 at N+1. The request is consumed at N+1, giving 502 at N+2.
5. TICK_BIT=4, set_time=14 → values 14, 17, 20, 24, 27, 30, 34. time_tick=1 on the cycles showing 17 and 34, 0 otherwise.
6. TIMER_WIDTH=8, set_time=254 → values 254, 1, 4, 8. time_tick=1 on the cycle showing 1. Asserting reset low mid-sequence returns current_time=INIT_TIME immediately.
